keypad_entry: RTL and testbench

- Input-side counterpart to the display path: scans a 4x4 matrix keypad, debounces it, and assembles up to 3 decimal digits.
- Converts the digits BCD-to-binary into an 8-bit value on Enter.
- Feeds the udl_counter load data/load strobe in place of switches; BCD digits are exported for echo on the 7-segment display.

---
 rtl/keypad_entry.sv | 206 ++++++++++++++++++++
 tb/tb_keypad_entry.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce, 3-digit BCD entry and BCD-to-binary commit on '#'.
// Define KEYPAD_ECHO_EN to add the echo[17:0] output in seven-segment driver field format.
module keypad_entry #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [11:0] digits,
    output logic [1:0]  count,
    output logic [7:0]  value,
    output logic        value_valid,
    output logic        overflow,
    output logic [3:0]  key_code,
    output logic        key_strobe
`ifdef KEYPAD_ECHO_EN
    ,
    output logic [17:0] echo
`endif
);

    localparam int DWELL_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W    = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]    DB_TARGET  = DB_W'(DEBOUNCE_SCANS);
    localparam bit                 DB_SINGLE  = (DEBOUNCE_SCANS == 1);

    localparam logic [1:0] ST_SCAN       = 2'd0;
    localparam logic [1:0] ST_PRESS_DB   = 2'd1;
    localparam logic [1:0] ST_PRESSED    = 2'd2;
    localparam logic [1:0] ST_RELEASE_DB = 2'd3;

    localparam logic [3:0] KEY_CLEAR = 4'd12;
    localparam logic [3:0] KEY_ENTER = 4'd14;
    localparam logic [3:0] ROWS_IDLE = 4'hF;

    logic [1:0]         state;
    logic [1:0]         col_idx;
    logic [DWELL_W-1:0] dwell;
    logic [DB_W-1:0]    db_cnt;
    logic [3:0]         row_lat;
    logic               sample;
    logic [4:0]         key_dec;
    logic [9:0]         entry_sum;

    // Row with the lowest index wins when several rows are pulled low.
    function automatic logic [1:0] low_row_idx(input logic [3:0] r);
        logic [1:0] idx;
        if (!r[0])      idx = 2'd0;
        else if (!r[1]) idx = 2'd1;
        else if (!r[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    // Returns {is_digit, bcd} for a key index {row, col}.
    function automatic logic [4:0] key_digit(input logic [3:0] code);
        logic [4:0] d;
        case (code)
            4'd0:    d = {1'b1, 4'd1};
            4'd1:    d = {1'b1, 4'd2};
            4'd2:    d = {1'b1, 4'd3};
            4'd4:    d = {1'b1, 4'd4};
            4'd5:    d = {1'b1, 4'd5};
            4'd6:    d = {1'b1, 4'd6};
            4'd8:    d = {1'b1, 4'd7};
            4'd9:    d = {1'b1, 4'd8};
            4'd10:   d = {1'b1, 4'd9};
            4'd13:   d = {1'b1, 4'd0};
            default: d = 5'd0;
        endcase
        return d;
    endfunction

    function automatic logic [9:0] bcd_to_bin(input logic [11:0] d);
        return 10'(d[11:8]) * 10'd100 + 10'(d[7:4]) * 10'd10 + 10'(d[3:0]);
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    assign sample     = (dwell == DWELL_LAST);
    assign col        = ~(4'b0001 << col_idx);
    assign key_strobe = (state == ST_PRESSED);
    assign key_dec    = key_digit(key_code);
    assign entry_sum  = bcd_to_bin(digits);

    // Scan / debounce control
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_SCAN;
            col_idx  <= 2'd0;
            dwell    <= '0;
            db_cnt   <= '0;
            key_code <= 4'd0;
        end else begin
            dwell <= sample ? '0 : dwell + 1'b1;
            case (state)
                ST_SCAN: begin
                    if (sample) begin
                        if (row == ROWS_IDLE) begin
                            col_idx <= col_idx + 2'd1;
                        end else if (DB_SINGLE) begin
                            state    <= ST_PRESSED;
                            key_code <= {low_row_idx(row), col_idx};
                            db_cnt   <= '0;
                        end else begin
                            state  <= ST_PRESS_DB;
                            db_cnt <= DB_W'(1);
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (sample) begin
                        if (row != row_lat) begin
                            state  <= ST_SCAN;
                            db_cnt <= '0;
                        end else if (db_cnt + 1'b1 == DB_TARGET) begin
                            state    <= ST_PRESSED;
                            key_code <= {low_row_idx(row), col_idx};
                            db_cnt   <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                end
                ST_PRESSED: begin
                    state  <= ST_RELEASE_DB;
                    db_cnt <= '0;
                end
                ST_RELEASE_DB: begin
                    // Column stays put until the key has been seen released long enough.
                    if (sample) begin
                        if (row != ROWS_IDLE) begin
                            db_cnt <= '0;
                        end else if (db_cnt + 1'b1 == DB_TARGET) begin
                            state   <= ST_SCAN;
                            col_idx <= col_idx + 2'd1;
                            db_cnt  <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_SCAN;
                    db_cnt <= '0;
                end
            endcase
        end
    end

    // Row pattern captured at first detection; compared on later debounce samples.
    always_ff @(posedge clk) begin
        if (state == ST_SCAN && sample && row != ROWS_IDLE)
            row_lat <= row;
    end

    // Key action stage: acts during the strobe cycle, results visible next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            digits      <= 12'd0;
            count       <= 2'd0;
            value       <= 8'd0;
            value_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            if (state == ST_PRESSED) begin
                if (key_dec[4]) begin
                    digits <= {digits[7:0], key_dec[3:0]};
                    count  <= sat_inc(count);
                end else if (key_code == KEY_CLEAR) begin
                    digits   <= 12'd0;
                    count    <= 2'd0;
                    overflow <= 1'b0;
                end else if (key_code == KEY_ENTER) begin
                    digits <= 12'd0;
                    count  <= 2'd0;
                    if (entry_sum[9:8] == 2'b00) begin
                        value       <= entry_sum[7:0];
                        value_valid <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef KEYPAD_ECHO_EN
    // Field p (0 = ones) is {en, bcd, dp}; en lights only the digits actually entered.
    always_comb begin
        echo = 18'd0;
        for (int p = 0; p < 3; p++) begin
            echo[p*6 +: 6] = {(p < int'(count)), digits[p*4 +: 4], 1'b0};
        end
    end
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a keypad model drives rows from the scanned column and
// expected key results are queued per press and checked when the strobe appears.
module tb_keypad_entry;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [11:0] digits;
    logic [1:0]  count;
    logic [7:0]  value;
    logic        value_valid;
    logic        overflow;
    logic [3:0]  key_code;
    logic        key_strobe;
`ifdef KEYPAD_ECHO_EN
    logic [17:0] echo;
`endif

    logic       key_down = 1'b0;
    logic [1:0] key_r = 2'd0;
    logic [1:0] key_c = 2'd0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  code;
        logic [11:0] digits;
        logic [1:0]  count;
        logic [7:0]  value;
        logic        ovf;
        logic        vv;
    } exp_t;

    exp_t sb[$];

    keypad_entry #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .digits     (digits),
        .count      (count),
        .value      (value),
        .value_valid(value_valid),
        .overflow   (overflow),
        .key_code   (key_code),
        .key_strobe (key_strobe)
`ifdef KEYPAD_ECHO_EN
        ,
        .echo       (echo)
`endif
    );

    always #5 clk = ~clk;

    // Pressed key shorts its row low only while its column is driven low.
    assign row = (key_down && col[key_c] == 1'b0) ? ~(4'b0001 << key_r) : 4'hF;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input string tag, input logic [3:0] target);
        int seen;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (col === target) begin
                seen = 1;
                break;
            end
        end
        check({tag, ".col_reached"}, seen, 1);
    endtask

    task automatic expect_key(input logic [3:0] code, input logic [11:0] d, input logic [1:0] c,
                              input logic [7:0] v, input logic ovf, input logic vv);
        exp_t e;
        e.code = code; e.digits = d; e.count = c; e.value = v; e.ovf = ovf; e.vv = vv;
        sb.push_back(e);
    endtask

    // Waits for the strobe, compares against the queued result, then holds and releases the key.
    task automatic collect(input string tag, input int want_lat);
        exp_t e;
        int   lat;
        int   extra;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (key_strobe === 1'b1) begin
                lat = i;
                break;
            end
        end
        e = sb.pop_front();
        check({tag, ".strobe_seen"}, (lat > 0), 1);
        if (lat > 0) begin
            if (want_lat > 0) check({tag, ".latency"}, lat, want_lat);
            check({tag, ".code"}, key_code, e.code);
            @(negedge clk);
            check({tag, ".strobe_width"}, key_strobe, 0);
            check({tag, ".digits"}, digits, e.digits);
            check({tag, ".count"}, count, e.count);
            check({tag, ".value"}, value, e.value);
            check({tag, ".overflow"}, overflow, e.ovf);
            check({tag, ".value_valid"}, value_valid, e.vv);
            @(negedge clk);
            check({tag, ".vv_width"}, value_valid, 0);
            extra = 0;
            repeat (12) begin
                @(negedge clk);
                extra += int'(key_strobe);
            end
            key_down = 1'b0;
            repeat (16) begin
                @(negedge clk);
                extra += int'(key_strobe);
            end
            check({tag, ".no_repeat"}, extra, 0);
        end else begin
            key_down = 1'b0;
            tick_n(16);
        end
    endtask

    task automatic press(input string tag, input logic [1:0] r, input logic [1:0] c,
                         input logic [11:0] d, input logic [1:0] n, input logic [7:0] v,
                         input logic ovf, input logic vv);
        expect_key({r, c}, d, n, v, ovf, vv);
        key_r    = r;
        key_c    = c;
        key_down = 1'b1;
        collect(tag, 0);
    endtask

    initial begin
        int strobes;

        reset = 1'b1;
        tick_n(2);
        check("rst.col", col, 4'b1110);
        check("rst.digits", digits, 0);
        check("rst.count", count, 0);
        check("rst.value", value, 0);
        check("rst.value_valid", value_valid, 0);
        check("rst.overflow", overflow, 0);
        check("rst.key_code", key_code, 0);
        check("rst.key_strobe", key_strobe, 0);
`ifdef KEYPAD_ECHO_EN
        check("rst.echo", echo, 0);
`endif
        reset = 1'b0;

        // Idle rotation, one column per SCAN_DIV clocks
        tick_n(3);
        check("rot.hold0", col, 4'b1110);
        tick_n(1);
        check("rot.c1", col, 4'b1101);
        tick_n(4);
        check("rot.c2", col, 4'b1011);
        tick_n(4);
        check("rot.c3", col, 4'b0111);
        tick_n(4);
        check("rot.c0", col, 4'b1110);

        // '2' bounces for one sample before settling
        expect_key(4'b0001, 12'h002, 2'd1, 8'd0, 1'b0, 1'b0);
        key_r = 2'd0;
        key_c = 2'd1;
        key_down = 1'b1;
        wait_col("bounce", 4'b1101);
        strobes = 0;
        repeat (4) begin
            @(negedge clk);
            strobes += int'(key_strobe);
        end
        key_down = 1'b0;
        repeat (4) begin
            @(negedge clk);
            strobes += int'(key_strobe);
        end
        check("bounce.no_strobe", strobes, 0);
        check("bounce.col_held", col, 4'b1101);
        key_down = 1'b1;
        collect("bounce_2", 8);

        press("clr0",  2'd3, 2'd0, 12'h000, 2'd0, 8'd0,   1'b0, 1'b0);
        press("a_2",   2'd0, 2'd1, 12'h002, 2'd1, 8'd0,   1'b0, 1'b0);
        press("a_5",   2'd1, 2'd1, 12'h025, 2'd2, 8'd0,   1'b0, 1'b0);
        press("a_5b",  2'd1, 2'd1, 12'h255, 2'd3, 8'd0,   1'b0, 1'b0);
        press("a_ent", 2'd3, 2'd2, 12'h000, 2'd0, 8'd255, 1'b0, 1'b1);

        press("b_2",   2'd0, 2'd1, 12'h002, 2'd1, 8'd255, 1'b0, 1'b0);
        press("b_5",   2'd1, 2'd1, 12'h025, 2'd2, 8'd255, 1'b0, 1'b0);
        press("b_6",   2'd1, 2'd2, 12'h256, 2'd3, 8'd255, 1'b0, 1'b0);
        press("b_ent", 2'd3, 2'd2, 12'h000, 2'd0, 8'd255, 1'b1, 1'b0);

        press("c_1",   2'd0, 2'd0, 12'h001, 2'd1, 8'd255, 1'b1, 1'b0);
        press("c_2",   2'd0, 2'd1, 12'h012, 2'd2, 8'd255, 1'b1, 1'b0);
        press("c_3",   2'd0, 2'd2, 12'h123, 2'd3, 8'd255, 1'b1, 1'b0);
        press("c_4",   2'd1, 2'd0, 12'h234, 2'd3, 8'd255, 1'b1, 1'b0);
        press("c_clr", 2'd3, 2'd0, 12'h000, 2'd0, 8'd255, 1'b0, 1'b0);

        press("d_A",   2'd0, 2'd3, 12'h000, 2'd0, 8'd255, 1'b0, 1'b0);
        press("d_ent0", 2'd3, 2'd2, 12'h000, 2'd0, 8'd0,  1'b0, 1'b1);

        // Reset while '7' is held mid-debounce
        wait_col("rst7.pre", 4'b1101);
        key_r = 2'd2;
        key_c = 2'd0;
        key_down = 1'b1;
        wait_col("rst7", 4'b1110);
        tick_n(4);
        reset = 1'b1;
        @(negedge clk);
        check("rst7.strobe_a", key_strobe, 0);
        @(negedge clk);
        check("rst7.strobe_b", key_strobe, 0);
        check("rst7.col", col, 4'b1110);
        reset = 1'b0;
        check("rst7.digits", digits, 0);
        check("rst7.value", value, 0);
        expect_key(4'b1000, 12'h007, 2'd1, 8'd0, 1'b0, 1'b0);
        collect("rst7_accept", 8);

`ifdef KEYPAD_ECHO_EN
        press("e_clr", 2'd3, 2'd0, 12'h000, 2'd0, 8'd0, 1'b0, 1'b0);
        press("e_4",   2'd1, 2'd0, 12'h004, 2'd1, 8'd0, 1'b0, 1'b0);
        press("e_2",   2'd0, 2'd1, 12'h042, 2'd2, 8'd0, 1'b0, 1'b0);
        check("echo.42", echo, {6'b0_0000_0, 6'b1_0100_0, 6'b1_0010_0});
`endif

        check("sb.drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
